// File: rtl/lc_fetch_if.sv
// Instruction fetch bus between lc_fetch (master) and instruction memory (slave).
// One outstanding request at a time; fetch_ack returns fetch_data for the requested word.
interface lc_fetch_if #(
    parameter int unsigned ADDR_W = 24
) ();
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [31:0]       fetch_data;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data
    );
endinterface

// File: rtl/lc_fetch.sv
// Location counter with a one-word instruction buffer; refetches whenever lc moves to a new
// word and drops any fetch that was in flight for the word it left.
module lc_fetch #(
    parameter int unsigned LC_WIDTH = 26,
    parameter int unsigned SUB_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                state_fetch,
    input  logic                destlc,
    input  logic                lcinc,
    input  logic [1:0]          lc_mode,
    input  logic [LC_WIDTH-1:0] ob,
    input  logic                srclc,
    output logic [LC_WIDTH-1:0] lc,
    output logic [31:0]         inst_word,
    output logic                inst_valid,
    output logic                needfetch,
    output logic [31:0]         mf,
    lc_fetch_if.master          fbus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StFull    = 2'd2;
    localparam logic [1:0] StDiscard = 2'd3;

    logic [LC_WIDTH-1:0] lc_q, lc_d, step;
    logic [1:0]          state_q, state_d;
    logic [31:0]         word_q, word_d;
    logic                word_chg;

    always_comb begin
        step = LC_WIDTH'(1);
        case (lc_mode)
            2'd0:    step = LC_WIDTH'(1);
            2'd1:    step = LC_WIDTH'(2);
            default: step = LC_WIDTH'(1) << SUB_BITS;
        endcase
    end

    always_comb begin
        lc_d = lc_q;
        if (state_fetch) begin
            if (destlc) begin
                lc_d = ob;
            end else if (lcinc) begin
                lc_d = lc_q + step;
            end
        end
    end

    // Only the word address matters; moving within a word keeps the buffer.
    assign word_chg = lc_d[LC_WIDTH-1:SUB_BITS] != lc_q[LC_WIDTH-1:SUB_BITS];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (word_chg) begin
                    // With an ack the bus is free, so re-request at once; otherwise wait it out.
                    state_d = fbus.fetch_ack ? StReq : StDiscard;
                end else if (fbus.fetch_ack) begin
                    word_d  = fbus.fetch_data;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (word_chg) begin
                    state_d = StReq;
                end
            end
            default: begin
                if (fbus.fetch_ack) begin
                    state_d = StReq;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lc_q    <= '0;
            state_q <= StIdle;
            word_q  <= '0;
        end else begin
            lc_q    <= lc_d;
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    assign lc              = lc_q;
    assign inst_word       = word_q;
    assign inst_valid      = state_q == StFull;
    assign needfetch       = ~inst_valid;
    assign fbus.fetch_req  = state_q == StReq;
    assign fbus.fetch_addr = lc_q[LC_WIDTH-1:SUB_BITS];
    assign mf              = srclc ? {needfetch, inst_valid, lc_mode, 28'(lc_q)} : 32'd0;

endmodule
